multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Sequential successor to the single-cycle RV32I control decoder: a multicycle control FSM driving a shared-memory datapath.
- Fetches over a variable-latency memory handshake and decodes R/I/load/store/branch/JAL/JALR/LUI/AUIPC.
- Sequences datapath enables per state and traps illegal encodings.
- Sits between the instruction register and the datapath muxes/enables of the multicycle core.

Parameters:
- ALU_CTRL_W, 4, width of alu_control.
- IMM_SRC_W, 3, width of imm_src.
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before bus_error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  instruction bits [6:0], from the instruction register.
- funct3  in  3  instruction bits [14:12].
- funct7  in  7  instruction bits [31:25].
- eq, lt, ltu  in  1 each  comparator flags, rs1 vs rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a store.
- adr_src  out  1  address select: 0=PC, 1=alu_out.
- ir_write  out  1  load the instruction register and old_pc.
- pc_write  out  1  PC load enable.
- reg_write  out  1  register-file write enable.
- imm_src  out  IMM_SRC_W  immediate format: I=000, S=001, B=010, J=011, U=100.
- alu_src_a  out  2  ALU A select: 00=rs1, 01=PC, 10=old_pc, 11=zero.
- alu_src_b  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4.
- result_src  out  2  writeback select: 00=alu_out reg, 01=mem data, 10=alu result.
- alu_control  out  ALU_CTRL_W  ALU operation code.
- instr_done  out  1  one-cycle pulse on retire.
- illegal_instr  out  1  one-cycle pulse in TRAP.
- bus_error  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset:
  - state=FETCH, timeout counter=0.
  - All outputs are Moore-decoded from state plus inputs, and deasserted/zero whenever rst=1.
- alu_control encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001.
  - R-type uses funct3 with funct7[5] to select SUB/SRA.
  - OP-IMM uses funct7[5] only for funct3=101 (SRAI). ADDI never maps to SUB.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, A=01, B=10, ADD.
  - Stays in FETCH while !mem_ready.
  - On mem_ready: ir_write=1 and pc_write=1 (PC+4), then go to DECODE.
- DECODE: A=10, B=01, imm_src=B (precomputes the branch target into alu_out). Next state by opcode:
  - 0000011 or 0100011: MEMADR.
  - 0110011: EXEC_R.
  - 0010011: EXEC_I.
  - 1100011: BRANCH.
  - 1101111: JAL.
  - 1100111: JALR.
  - 0110111 or 0010111: UPPER.
  - Any other opcode: TRAP.
- MEMADR: A=00, B=01, ADD; imm_src=I for loads, S for stores. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1; holds until mem_ready, then MEMWB.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready, instr_done=1 and next state FETCH.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- EXEC_R: A=00, B=00, decoded op, then ALUWB.
- EXEC_I: A=00, B=01, imm_src=I, decoded op, then ALUWB.
- UPPER: A=11 for LUI or 01-via-old_pc (10) for AUIPC, B=01, imm_src=U, ADD, then ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH:
  - Outputs: A=00, B=00, SUB, result_src=00.
  - pc_write = taken, where taken is by funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011 goes to TRAP with no pc_write.
  - Otherwise instr_done=1 and next state FETCH.
- JAL:
  - Cycle 1: A=10, B=01, imm_src=J; pc_write=1 using the ALU result (result_src=10).
  - Cycle 2 (LINK state): A=10, B=10, ADD, result_src=10, reg_write=1, instr_done=1, then FETCH.
- JALR: A=00, B=01, imm_src=I, pc_write=1 with result_src=10, then LINK.
- TRAP: illegal_instr=1, no writes, then FETCH.
- Timeout (MEM_TIMEOUT>0):
  - The counter increments each cycle mem_req=1 && !mem_ready and clears on mem_ready or state change.
  - When it reaches MEM_TIMEOUT: bus_error=1, the access is abandoned, no writes, next state FETCH (same PC).
- Simultaneous mem_ready and timeout threshold: mem_ready wins.
- rst asserted mid-instruction: next cycle is FETCH with all enables 0. No partial write may occur in the reset cycle.

Optional Feature:
- Macro CTRL_PERF_EN.
- When defined, adds two outputs:
  - cycle_count[31:0]: +1 every non-reset cycle.
  - instret_count[31:0]: +1 on each instr_done.
  - Both are cleared by rst and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ADD (0110011/000/0000000), mem_ready=1 in FETCH:
  - FETCH→DECODE→EXEC_R→ALUWB.
  - alu_control=0000; reg_write=1 only in ALUWB; instr_done after exactly 4 cycles.
- SW (0100011/010) with mem_ready delayed 3 cycles in MEMWRITE: mem_req=1 and mem_write=1 held for 4 cycles, imm_src=001 in MEMADR, no reg_write.
- BNE with eq=0 then with eq=1:
  - pc_write=1 in BRANCH for eq=0, and 0 for eq=1.
  - alu_control=0001; funct3=010 gives illegal_instr=1.
- JAL: pc_write in JAL state; LINK state shows reg_write=1, A=10, B=10.
- Opcode 1111111: TRAP, illegal_instr pulses once, no reg_write, no mem_write, returns to FETCH.
- MEM_TIMEOUT=4, mem_ready never asserts in FETCH:
  - bus_error pulses on the 4th wait cycle and the FSM returns to FETCH.
  - rst mid-LOAD forces FETCH with all outputs 0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM of a multicycle RV32I core with a shared
// instruction/data memory. Fetches over a variable-latency ready handshake,
// decodes the instruction register, sequences datapath selects/enables per
// state, traps illegal encodings and abandons memory accesses that time out.
// Optional build macro: CTRL_PERF_EN adds cycle_count / instret_count outputs.
module multicycle_control #(
    parameter int ALU_CTRL_W  = 4,
    parameter int IMM_SRC_W   = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  eq,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instr_done,
    output logic                  illegal_instr,
    output logic                  bus_error
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           instret_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_UPPER    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_LINK     = 4'd12,
        S_JALR     = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [IMM_SRC_W-1:0] IMM_I = IMM_SRC_W'(3'b000);
    localparam logic [IMM_SRC_W-1:0] IMM_S = IMM_SRC_W'(3'b001);
    localparam logic [IMM_SRC_W-1:0] IMM_B = IMM_SRC_W'(3'b010);
    localparam logic [IMM_SRC_W-1:0] IMM_J = IMM_SRC_W'(3'b011);
    localparam logic [IMM_SRC_W-1:0] IMM_U = IMM_SRC_W'(3'b100);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0001);

    // Wait counter only needs to hold MEM_TIMEOUT-1: the timeout fires on that value.
    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic               timeout_hit_s;
    logic               unused_funct7_s;

    assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

    // ALU operation from funct3/funct7[5]; SUB only for R-type, SRA/SRAI for both.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? 4'b0001 : 4'b0000;
            3'b001:  op = 4'b0101;
            3'b010:  op = 4'b1000;
            3'b011:  op = 4'b1001;
            3'b100:  op = 4'b0100;
            3'b101:  op = f7b5 ? 4'b0111 : 4'b0110;
            3'b110:  op = 4'b0011;
            3'b111:  op = 4'b0010;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

    // Branch condition from funct3 and the comparator flags.
    function automatic logic branch_taken(input logic [2:0] f3, input logic f_eq,
                                          input logic f_lt, input logic f_ltu);
        logic tk;
        case (f3)
            3'b000:  tk = f_eq;
            3'b001:  tk = !f_eq;
            3'b100:  tk = f_lt;
            3'b101:  tk = !f_lt;
            3'b110:  tk = f_ltu;
            3'b111:  tk = !f_ltu;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    // Next-state, Moore-style outputs and memory wait counter.
    always_comb begin
        state_d       = state_q;
        to_cnt_d      = '0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        imm_src       = IMM_I;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_control   = ALU_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        timeout_hit_s = TO_EN && (to_cnt_q == CNT_LAST) && !mem_ready;

        if (rst) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout_hit_s) begin
                        bus_error = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_B;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                        default:           state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_b = 2'b01;
                    if (opcode == OP_STORE) begin
                        imm_src = IMM_S;
                        state_d = S_MEMWRITE;
                    end else begin
                        imm_src = IMM_I;
                        state_d = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (timeout_hit_s) begin
                        bus_error = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_MEMREAD;
                    end
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (timeout_hit_s) begin
                        bus_error = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_MEMWRITE;
                    end
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_control = ALU_CTRL_W'(alu_decode(funct3, funct7[5], 1'b1));
                    state_d     = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_b   = 2'b01;
                    imm_src     = IMM_I;
                    alu_control = ALU_CTRL_W'(alu_decode(funct3, funct7[5], 1'b0));
                    state_d     = S_ALUWB;
                end
                S_UPPER: begin
                    // LUI adds the immediate to zero; AUIPC adds it to the instruction's PC.
                    alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_control = ALU_SUB;
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        state_d = S_TRAP;
                    end else begin
                        pc_write   = branch_taken(funct3, eq, lt, ltu);
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_JAL: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    imm_src    = IMM_J;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    state_d    = S_LINK;
                end
                S_JALR: begin
                    alu_src_b  = 2'b01;
                    imm_src    = IMM_I;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    state_d    = S_LINK;
                end
                S_LINK: begin
                    // Link value is old_pc + 4, written while the PC already holds the target.
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase

            // Count consecutive stalled request cycles within one state.
            if (TO_EN && mem_req && !mem_ready && !bus_error && (state_d == state_q)) begin
                to_cnt_d = to_cnt_q + CNT_W'(1);
            end else begin
                to_cnt_d = '0;
            end
        end
    end

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

`ifdef CTRL_PERF_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    // Performance counter increments; both wrap naturally at 2^32.
    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q;
        if (instr_done) begin
            instret_d = instret_q + 32'd1;
        end else begin
            instret_d = instret_q;
        end
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (MEM_TIMEOUT = 4). Each task walks
// one instruction class through the FSM and compares the full output vector
// against hand-written expectations every cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       eq = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control;
    logic       instr_done, illegal_instr, bus_error;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_count, instret_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [21:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src,
                  alu_src_a, alu_src_b, result_src, alu_control,
                  instr_done, illegal_instr, bus_error};

    multicycle_control #(
        .ALU_CTRL_W (4),
        .IMM_SRC_W  (3),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .eq           (eq),
        .lt           (lt),
        .ltu          (ltu),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_write    (mem_write),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .imm_src      (imm_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .result_src   (result_src),
        .alu_control  (alu_control),
        .instr_done   (instr_done),
        .illegal_instr(illegal_instr),
        .bus_error    (bus_error)
`ifdef CTRL_PERF_EN
        ,
        .cycle_count  (cycle_count),
        .instret_count(instret_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected output vector, fields in the same order as obs.
    function automatic logic [21:0] ev(input logic mreq, input logic mwr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [2:0] imm, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [3:0] alu, input logic done,
                                       input logic ill, input logic berr);
        return {mreq, mwr, adr, irw, pcw, rw, imm, a, b, res, alu, done, ill, berr};
    endfunction

    logic [21:0] E_FETCH_WAIT, E_FETCH_GO, E_DECODE;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // FETCH with immediate ready, then DECODE; leaves the FSM in the execute state.
    task automatic run_fetch_decode;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_ready = 1'b1;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick();
        tick();
        n_cmp++;
        if (obs !== 22'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 22'd0);
        end
`ifdef CTRL_PERF_EN
        n_cmp++;
        if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
            n_err++; $display("FAIL reset_perf: got %0d/%0d want 0/0", cycle_count, instret_count);
        end
`endif
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_FETCH_WAIT) begin
            n_err++; $display("FAIL reset_fetch: got %h want %h", obs, E_FETCH_WAIT);
        end
    endtask

    task automatic test_add;
        logic [21:0] e;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== E_FETCH_GO) begin
            n_err++; $display("FAIL add_fetch: got %h want %h", obs, E_FETCH_GO);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_DECODE) begin
            n_err++; $display("FAIL add_decode: got %h want %h", obs, E_DECODE);
        end
        tick();
        e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL add_exec: got %h want %h", obs, e);
        end
        tick();
        e = ev(0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL add_aluwb: got %h want %h", obs, e);
        end
        tick();
    endtask

    task automatic test_alu_ops;
        // {opcode, funct3, funct7, expected alu_control}
        logic [20:0] tbl [11];
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [21:0] e;
        tbl = '{
            {7'b0110011, 3'b000, 7'b0100000, 4'b0001},
            {7'b0110011, 3'b101, 7'b0100000, 4'b0111},
            {7'b0110011, 3'b101, 7'b0000000, 4'b0110},
            {7'b0110011, 3'b011, 7'b0000000, 4'b1001},
            {7'b0110011, 3'b111, 7'b0000000, 4'b0010},
            {7'b0110011, 3'b001, 7'b0000000, 4'b0101},
            {7'b0010011, 3'b000, 7'b0100000, 4'b0000},
            {7'b0010011, 3'b101, 7'b0100000, 4'b0111},
            {7'b0010011, 3'b100, 7'b0000000, 4'b0100},
            {7'b0010011, 3'b010, 7'b0000000, 4'b1000},
            {7'b0010011, 3'b110, 7'b0000000, 4'b0011}
        };
        for (int i = 0; i < 11; i++) begin
            {op, f3, f7, alu} = tbl[i];
            set_instr(op, f3, f7);
            run_fetch_decode();
            if (op == 7'b0010011)
                e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 2'b00, alu, 0, 0, 0);
            else
                e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, alu, 0, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL alu_op[%0d]: got %h want %h", i, obs, e);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_upper;
        logic [21:0] e;
        for (int i = 0; i < 2; i++) begin
            set_instr((i == 0) ? 7'b0110111 : 7'b0010111, 3'b000, 7'b0000000);
            run_fetch_decode();
            e = ev(0, 0, 0, 0, 0, 0, 3'b100, (i == 0) ? 2'b11 : 2'b10, 2'b01, 2'b00,
                   4'b0000, 0, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL upper[%0d]: got %h want %h", i, obs, e);
            end
            tick();
            e = ev(0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL upper_wb[%0d]: got %h want %h", i, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_store;
        logic [21:0] e;
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        run_fetch_decode();
        e = ev(0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 2'b01, 2'b00, 4'b0000, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL sw_memadr: got %h want %h", obs, e);
        end
        tick();
        // Ready arrives on the 4th request cycle, the same cycle the timeout would fire.
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            e = ev(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, (k == 3), 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL sw_memwrite[%0d]: got %h want %h", k, obs, e);
            end
            tick();
        end
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_FETCH_WAIT) begin
            n_err++; $display("FAIL sw_return: got %h want %h", obs, E_FETCH_WAIT);
        end
    endtask

    task automatic test_load;
        logic [21:0] e;
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        run_fetch_decode();
        e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 2'b00, 4'b0000, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL lw_memadr: got %h want %h", obs, e);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            mem_ready = (k == 1);
            #1;
            e = ev(1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL lw_memread[%0d]: got %h want %h", k, obs, e);
            end
            tick();
        end
        mem_ready = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b01, 4'b0000, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL lw_memwb: got %h want %h", obs, e);
        end
        tick();
    endtask

    task automatic test_branch;
        // {funct3, eq, lt, ltu, taken}
        logic [6:0]  tbl [8];
        logic [2:0]  f3;
        logic        tk;
        logic [21:0] e;
        tbl = '{
            {3'b001, 1'b0, 1'b0, 1'b0, 1'b1},
            {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
            {3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
            {3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
            {3'b100, 1'b0, 1'b1, 1'b0, 1'b1},
            {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'b110, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'b111, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            {f3, eq, lt, ltu, tk} = tbl[i];
            set_instr(7'b1100011, f3, 7'b0000000);
            run_fetch_decode();
            e = ev(0, 0, 0, 0, tk, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0001, 1, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL branch[%0d]: got %h want %h", i, obs, e);
            end
            tick();
        end
        eq = 1'b1;
        set_instr(7'b1100011, 3'b010, 7'b0000000);
        run_fetch_decode();
        e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0001, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL branch_bad_f3: got %h want %h", obs, e);
        end
        tick();
        e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL branch_trap: got %h want %h", obs, e);
        end
        tick();
        eq = 1'b0;
    endtask

    task automatic test_jumps;
        logic [21:0] e;
        set_instr(7'b1101111, 3'b000, 7'b0000000);
        run_fetch_decode();
        e = ev(0, 0, 0, 0, 1, 0, 3'b011, 2'b10, 2'b01, 2'b10, 4'b0000, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL jal: got %h want %h", obs, e);
        end
        tick();
        e = ev(0, 0, 0, 0, 0, 1, 3'b000, 2'b10, 2'b10, 2'b10, 4'b0000, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL jal_link: got %h want %h", obs, e);
        end
        tick();
        set_instr(7'b1100111, 3'b000, 7'b0000000);
        run_fetch_decode();
        e = ev(0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 2'b01, 2'b10, 4'b0000, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL jalr: got %h want %h", obs, e);
        end
        tick();
        e = ev(0, 0, 0, 0, 0, 1, 3'b000, 2'b10, 2'b10, 2'b10, 4'b0000, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL jalr_link: got %h want %h", obs, e);
        end
        tick();
    endtask

    task automatic test_trap;
        logic [21:0] e;
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_DECODE) begin
            n_err++; $display("FAIL trap_decode: got %h want %h", obs, E_DECODE);
        end
        tick();
        e = ev(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++; $display("FAIL trap_state: got %h want %h", obs, e);
        end
        tick();
        n_cmp++;
        if (obs !== E_FETCH_WAIT) begin
            n_err++; $display("FAIL trap_return: got %h want %h", obs, E_FETCH_WAIT);
        end
    endtask

    task automatic test_timeout;
        logic [21:0] e;
        mem_ready = 1'b0;
        // Two rounds in FETCH: the second shows the counter restarted after the timeout.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                #1;
                e = E_FETCH_WAIT | {21'd0, (k == 3)};
                n_cmp++;
                if (obs !== e) begin
                    n_err++; $display("FAIL fetch_timeout[%0d][%0d]: got %h want %h", r, k, obs, e);
                end
                tick();
            end
        end
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        run_fetch_decode();
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            e = ev(1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, (k == 3));
            n_cmp++;
            if (obs !== e) begin
                n_err++; $display("FAIL load_timeout[%0d]: got %h want %h", k, obs, e);
            end
            tick();
        end
        n_cmp++;
        if (obs !== E_FETCH_WAIT) begin
            n_err++; $display("FAIL load_timeout_return: got %h want %h", obs, E_FETCH_WAIT);
        end
    endtask

    task automatic test_reset_mid;
        // Reset during MEMWB (load) and during a ready MEMWRITE (store).
        for (int i = 0; i < 2; i++) begin
            set_instr((i == 0) ? 7'b0000011 : 7'b0100011, 3'b010, 7'b0000000);
            run_fetch_decode();
            tick();
            if (i == 0) begin
                mem_ready = 1'b1;
                tick();
            end
            mem_ready = 1'b1;
            rst = 1'b1;
            #1;
            n_cmp++;
            if (obs !== 22'd0) begin
                n_err++; $display("FAIL rst_mid[%0d]: got %h want %h", i, obs, 22'd0);
            end
            tick();
            rst = 1'b0;
            mem_ready = 1'b0;
            #1;
            n_cmp++;
            if (obs !== E_FETCH_WAIT) begin
                n_err++; $display("FAIL rst_mid_fetch[%0d]: got %h want %h", i, obs, E_FETCH_WAIT);
            end
        end
    endtask

    initial begin
        E_FETCH_WAIT = ev(1, 0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b10, 2'b00, 4'b0000, 0, 0, 0);
        E_FETCH_GO   = ev(1, 0, 0, 1, 1, 0, 3'b000, 2'b01, 2'b10, 2'b00, 4'b0000, 0, 0, 0);
        E_DECODE     = ev(0, 0, 0, 0, 0, 0, 3'b010, 2'b10, 2'b01, 2'b00, 4'b0000, 0, 0, 0);
        test_reset();
        test_add();
        test_alu_ops();
        test_upper();
        test_store();
        test_load();
        test_branch();
        test_jumps();
        test_trap();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
